// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, funct codes (which double as ALU operation codes),
// FSM states and PC source selects.
package ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] R_FORMAT = 6'b000000;
    localparam logic [5:0] J        = 6'b000010;
    localparam logic [5:0] BEQ      = 6'b000100;
    localparam logic [5:0] BNE      = 6'b000101;
    localparam logic [5:0] ADDI     = 6'b001000;
    localparam logic [5:0] SLTI     = 6'b001010;
    localparam logic [5:0] SLTIU    = 6'b001011;
    localparam logic [5:0] ANDI     = 6'b001100;
    localparam logic [5:0] ORI      = 6'b001101;
    localparam logic [5:0] XORI     = 6'b001110;
    localparam logic [5:0] LW       = 6'b100011;
    localparam logic [5:0] SW       = 6'b101011;

    // Funct codes (IR[5:0]), also used as ALU operation encodings
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Opcodes that proceed to EXEC (J is handled in DECODE)
    function automatic logic goes_to_exec(input logic [5:0] op);
        case (op)
            R_FORMAT, LW, SW, ADDI, ANDI, ORI, XORI,
            SLTI, SLTIU, BEQ, BNE: goes_to_exec = 1'b1;
            default:               goes_to_exec = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the controller and the datapath: instruction
// fields and status in, per-state datapath controls out.
interface multicycle_controller_if #(
    parameter int ALUOP_W = 6
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               mem_ready;
    logic               alu_zero;
    logic               PCWrite;
    logic [1:0]         PCSrc;
    logic               IorD;
    logic               IRWrite;
    logic               RegDst;
    logic               ALUsrc;
    logic [ALUOP_W-1:0] ALUop;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               RegWrite;
    logic               instr_done;
    logic               trap;
    logic               bus_err;

    modport master (
        input  opcode, funct, mem_ready, alu_zero,
        output PCWrite, PCSrc, IorD, IRWrite, RegDst, ALUsrc, ALUop,
               MemRead, MemWrite, MemtoReg, RegWrite, instr_done, trap, bus_err
    );

    modport slave (
        output opcode, funct, mem_ready, alu_zero,
        input  PCWrite, PCSrc, IorD, IRWrite, RegDst, ALUsrc, ALUop,
               MemRead, MemWrite, MemtoReg, RegWrite, instr_done, trap, bus_err
    );
endinterface

// File: rtl/alu_op_decode.sv
// Maps (opcode, funct) to the ALU operation code. R-type passes funct
// through; memory ops add; immediates pick their ALU function;
// branches subtract for the equality compare.
module alu_op_decode
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 6
) (
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    output logic [ALUOP_W-1:0] aluop_o
);
    logic [5:0] op6;

    // Opcode to ALU function lookup
    always_comb begin
        op6 = 6'd0;
        case (opcode_i)
            R_FORMAT:     op6 = funct_i;
            LW, SW, ADDI: op6 = F_ADD;
            ANDI:         op6 = F_AND;
            ORI:          op6 = F_OR;
            XORI:         op6 = F_XOR;
            SLTI:         op6 = F_SLT;
            SLTIU:        op6 = F_SLTU;
            BEQ, BNE:     op6 = F_SUB;
            default:      op6 = 6'd0;
        endcase
    end

    assign aluop_o = ALUOP_W'(op6);
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-ready
// wait counter and timeout, branch/jump handling and a sticky trap state
// for illegal opcodes and bus errors.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_controller_if.master bus
);
    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [5:0]      op_q, op_d, fn_q, fn_d;
    logic            trap_q, trap_d, berr_q, berr_d;
    logic            timeout;
    logic [ALUOP_W-1:0] dec_aluop;

    logic               pcw, iord, irw, regdst, alusrc, mr, mw, m2r, rw, done;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;

    alu_op_decode #(.ALUOP_W(ALUOP_W)) u_alu_op_decode (
        .opcode_i (op_q),
        .funct_i  (fn_q),
        .aluop_o  (dec_aluop)
    );

    // Saturating increment so the counter cannot wrap with timeout disabled
    assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign timeout = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                     (cnt_q == TO_W'(MEM_TIMEOUT - 1));

    // State, wait counter, latched instruction fields and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            fn_q    <= '0;
            trap_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            trap_q  <= trap_d;
            berr_q  <= berr_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        op_d    = op_q;
        fn_d    = fn_q;
        trap_d  = trap_q;
        berr_d  = berr_q;
        pcw     = 1'b0;
        pcsrc   = PCSRC_SEQ;
        iord    = 1'b0;
        irw     = 1'b0;
        regdst  = 1'b0;
        alusrc  = 1'b0;
        aluop   = '0;
        mr      = 1'b0;
        mw      = 1'b0;
        m2r     = 1'b0;
        rw      = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mr = 1'b1;
                if (bus.mem_ready) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        berr_d  = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                op_d = bus.opcode;
                fn_d = bus.funct;
                if (bus.opcode == J) begin
                    pcw     = 1'b1;
                    pcsrc   = PCSRC_JMP;
                    done    = 1'b1;
                    state_d = S_FETCH;
                end else if (goes_to_exec(bus.opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end
            end
            S_EXEC: begin
                aluop = dec_aluop;
                case (op_q)
                    R_FORMAT: state_d = S_WB;
                    LW, SW: begin
                        alusrc  = 1'b1;
                        state_d = S_MEM;
                    end
                    BEQ, BNE: begin
                        pcw     = (op_q == BEQ) ? bus.alu_zero : !bus.alu_zero;
                        pcsrc   = PCSRC_BR;
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        alusrc  = 1'b1;
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                iord   = 1'b1;
                alusrc = 1'b1;
                aluop  = dec_aluop;
                mr     = (op_q == LW);
                mw     = (op_q == SW);
                if (bus.mem_ready) begin
                    if (op_q == LW) begin
                        state_d = S_WB;
                    end else begin
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        berr_d  = 1'b1;
                    end
                end
            end
            S_WB: begin
                rw      = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
                if (op_q == R_FORMAT) begin
                    regdst = 1'b1;
                end else if (op_q == LW) begin
                    m2r = 1'b1;
                end else begin
                    alusrc = 1'b1;
                    aluop  = dec_aluop;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Controls (including memory requests) drop asynchronously with reset
    assign bus.PCWrite    = reset_n & pcw;
    assign bus.PCSrc      = reset_n ? pcsrc : PCSRC_SEQ;
    assign bus.IorD       = reset_n & iord;
    assign bus.IRWrite    = reset_n & irw;
    assign bus.RegDst     = reset_n & regdst;
    assign bus.ALUsrc     = reset_n & alusrc;
    assign bus.ALUop      = reset_n ? aluop : '0;
    assign bus.MemRead    = reset_n & mr;
    assign bus.MemWrite   = reset_n & mw;
    assign bus.MemtoReg   = reset_n & m2r;
    assign bus.RegWrite   = reset_n & rw;
    assign bus.instr_done = reset_n & done;
    assign bus.trap       = reset_n & trap_q;
    assign bus.bus_err    = reset_n & berr_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4). Each driven
// cycle pushes its hand-computed control vector into a scoreboard; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset_n;

    multicycle_controller_if #(.ALUOP_W(6)) bus ();

    multicycle_controller #(.ALUOP_W(6), .MEM_TIMEOUT(4), .TO_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [19:0] act;
    assign act = {bus.PCWrite, bus.PCSrc, bus.IorD, bus.IRWrite, bus.RegDst,
                  bus.ALUsrc, bus.ALUop, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                  bus.RegWrite, bus.instr_done, bus.trap, bus.bus_err};

    function automatic logic [19:0] mk(input logic pcw, input logic [1:0] pcs,
        input logic iord, input logic irw, input logic rd, input logic as,
        input logic [5:0] aop, input logic mr, input logic mw, input logic m2r,
        input logic rw, input logic dn, input logic tr, input logic be);
        mk = {pcw, pcs, iord, irw, rd, as, aop, mr, mw, m2r, rw, dn, tr, be};
    endfunction

    // Monitor: compare outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (act !== x.v) begin
                errors++;
                $display("FAIL %s act=%b exp=%b", x.nm, act, x.v);
            end
        end
    end

    task automatic step(input string nm, input logic rn, input logic [5:0] op,
                        input logic [5:0] fn, input logic rdy, input logic zero,
                        input logic [19:0] e);
        reset_n       = rn;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = rdy;
        bus.alu_zero  = zero;
        sb.push_back('{nm, e});
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] X = 6'h3f;

    logic [19:0] Z, FW, FO, TR, TB, DJ;
    logic [19:0] E_ADD, E_SUB, WB_R, WB_LW;
    logic [19:0] M_LW, M_SW, E_MEM, BR_T, BR_N;

    initial begin
        Z     = '0;
        FW    = mk(0,0,0,0,0,0,6'h00,1,0,0,0,0,0,0);
        FO    = mk(1,0,0,1,0,0,6'h00,1,0,0,0,0,0,0);
        TR    = mk(0,0,0,0,0,0,6'h00,0,0,0,0,0,1,0);
        TB    = mk(0,0,0,0,0,0,6'h00,0,0,0,0,0,1,1);
        DJ    = mk(1,2,0,0,0,0,6'h00,0,0,0,0,1,0,0);
        E_ADD = mk(0,0,0,0,0,0,6'h20,0,0,0,0,0,0,0);
        E_MEM = mk(0,0,0,0,0,1,6'h20,0,0,0,0,0,0,0);
        WB_R  = mk(0,0,0,0,1,0,6'h00,0,0,0,1,1,0,0);
        WB_LW = mk(0,0,0,0,0,0,6'h00,0,0,1,1,1,0,0);
        M_LW  = mk(0,0,1,0,0,1,6'h20,1,0,0,0,0,0,0);
        M_SW  = mk(0,0,1,0,0,1,6'h20,0,1,0,0,1,0,0);
        BR_T  = mk(1,1,0,0,0,0,6'h22,0,0,0,0,1,0,0);
        BR_N  = mk(0,1,0,0,0,0,6'h22,0,0,0,0,1,0,0);
        E_SUB = BR_N;

        reset_n = 1'b0;
        bus.opcode = X; bus.funct = X; bus.mem_ready = 1'b1; bus.alu_zero = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds every output low, even with mem_ready high
        step("rst0", 0, X, X, 1, 1, Z);
        step("rst1", 0, X, X, 0, 0, Z);

        // ADD R-type, zero-wait: 4 cycles
        step("add_f",  1, X,     X,     1, 0, FO);
        step("add_d",  1, 6'h00, 6'h20, 1, 0, Z);
        step("add_e",  1, X,     X,     1, 0, E_ADD);
        step("add_wb", 1, X,     X,     1, 0, WB_R);

        // LW with 3 wait cycles in MEM (ready on the last allowed cycle)
        step("lw_f",  1, X,     X, 1, 0, FO);
        step("lw_d",  1, 6'h23, X, 1, 0, Z);
        step("lw_e",  1, X,     X, 1, 0, E_MEM);
        step("lw_m0", 1, X,     X, 0, 0, M_LW);
        step("lw_m1", 1, X,     X, 0, 0, M_LW);
        step("lw_m2", 1, X,     X, 0, 0, M_LW);
        step("lw_m3", 1, X,     X, 1, 0, M_LW);
        step("lw_wb", 1, X,     X, 1, 0, WB_LW);

        // BEQ taken, BNE not taken, BNE taken
        step("beq_f",  1, X,     X, 1, 1, FO);
        step("beq_d",  1, 6'h04, X, 1, 1, Z);
        step("beq_e",  1, X,     X, 1, 1, BR_T);
        step("bne_f",  1, X,     X, 1, 1, FO);
        step("bne_d",  1, 6'h05, X, 1, 1, Z);
        step("bne_e",  1, X,     X, 1, 1, E_SUB);
        step("bne0_f", 1, X,     X, 1, 0, FO);
        step("bne0_d", 1, 6'h05, X, 1, 0, Z);
        step("bne0_e", 1, X,     X, 1, 0, BR_T);

        // J: jump in DECODE, FETCH again on cycle 3 (one wait cycle)
        step("j_f",  1, X,     X, 1, 0, FO);
        step("j_d",  1, 6'h02, X, 1, 0, DJ);
        step("j_f3", 1, X,     X, 0, 0, FW);

        // SW zero-wait in MEM: 4 cycles
        step("sw_f", 1, X,     X, 1, 0, FO);
        step("sw_d", 1, 6'h2b, X, 1, 0, Z);
        step("sw_e", 1, X,     X, 1, 0, E_MEM);
        step("sw_m", 1, X,     X, 1, 0, M_SW);

        // Immediates: ORI and SLTIU keep ALUsrc/ALUop into WB
        step("ori_f",    1, X,     X, 1, 0, FO);
        step("ori_d",    1, 6'h0d, X, 1, 0, Z);
        step("ori_e",    1, X,     X, 1, 0, mk(0,0,0,0,0,1,6'h25,0,0,0,0,0,0,0));
        step("ori_wb",   1, X,     X, 1, 0, mk(0,0,0,0,0,1,6'h25,0,0,0,1,1,0,0));
        step("sltiu_f",  1, X,     X, 1, 0, FO);
        step("sltiu_d",  1, 6'h0b, X, 1, 0, Z);
        step("sltiu_e",  1, X,     X, 1, 0, mk(0,0,0,0,0,1,6'h2b,0,0,0,0,0,0,0));
        step("sltiu_wb", 1, X,     X, 1, 0, mk(0,0,0,0,0,1,6'h2b,0,0,0,1,1,0,0));

        // FETCH ready on the 4th cycle: no trap; then illegal opcode
        step("fw0",    1, X,     X, 0, 0, FW);
        step("fw1",    1, X,     X, 0, 0, FW);
        step("fw2",    1, X,     X, 0, 0, FW);
        step("fw3_ok", 1, X,     X, 1, 0, FO);
        step("ill_d",  1, 6'h3f, X, 1, 0, Z);
        step("ill_t0", 1, X,     X, 1, 1, TR);
        step("ill_t1", 1, 6'h00, X, 1, 1, TR);
        step("ill_rst", 0, X,    X, 1, 1, Z);

        // FETCH timeout: 4 cycles without mem_ready -> bus error
        step("to_f0", 1, X, X, 0, 0, FW);
        step("to_f1", 1, X, X, 0, 0, FW);
        step("to_f2", 1, X, X, 0, 0, FW);
        step("to_f3", 1, X, X, 0, 0, FW);
        step("to_t0", 1, X, X, 1, 0, TB);
        step("to_t1", 1, X, X, 1, 1, TB);
        step("to_rst", 0, X, X, 1, 0, Z);

        // Reset mid-MEM drops the read request immediately
        step("ab_f",   1, X,     X, 1, 0, FO);
        step("ab_d",   1, 6'h23, X, 1, 0, Z);
        step("ab_e",   1, X,     X, 1, 0, E_MEM);
        step("ab_m0",  1, X,     X, 0, 0, M_LW);
        step("ab_rst", 0, X,     X, 0, 0, Z);

        // MEM timeout on LW
        step("mt_f",  1, X,     X, 1, 0, FO);
        step("mt_d",  1, 6'h23, X, 1, 0, Z);
        step("mt_e",  1, X,     X, 1, 0, E_MEM);
        step("mt_m0", 1, X,     X, 0, 0, M_LW);
        step("mt_m1", 1, X,     X, 0, 0, M_LW);
        step("mt_m2", 1, X,     X, 0, 0, M_LW);
        step("mt_m3", 1, X,     X, 0, 0, M_LW);
        step("mt_t",  1, X,     X, 1, 0, TB);

        // Recovery after reset
        step("rec_rst", 0, X, X, 0, 0, Z);
        step("rec_f",   1, X, X, 0, 0, FW);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
